// File: rtl/matriz_pkg.sv
// Shared constants, opcodes, FSM encoding and indexing helpers for the
// 5x5 signed 8-bit matrix coprocessor controller.
package matriz_pkg;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int ROW_W  = DIM * ELEM_W;
  localparam int MAT_W  = DIM * ROW_W;

  localparam logic [2:0] OP_ADD       = 3'd0;
  localparam logic [2:0] OP_SUB       = 3'd1;
  localparam logic [2:0] OP_MUL       = 3'd2;
  localparam logic [2:0] OP_SCALE     = 3'd3;
  localparam logic [2:0] OP_TRANSPOSE = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2,
    ERRO = 2'd3
  } estado_t;

  // Bit offset of element (r,c) inside a flattened matrix.
  function automatic int idx(input int r, input int c);
    return ELEM_W * (c + DIM * r);
  endfunction

  // A command is accepted only with a defined opcode and a size of 1..DIM.
  function automatic logic cmd_valido(input logic [2:0] op, input logic [2:0] n);
    return (op <= OP_TRANSPOSE) && (n >= 3'd1) && (n <= 3'(DIM));
  endfunction

endpackage

// File: rtl/matriz_linha_alu.sv
// Combinational row ALU: produces one full result row (DIM elements) for
// the selected row index from the latched operands. Columns at or beyond
// the active size are forced to zero.
//
// Every element is computed directly in ELEM_W bits. The stored value is the
// low byte of the full-precision signed result, and reduction modulo 256
// commutes with addition, subtraction and multiplication, so the low byte
// obtained here is exactly the low byte of the wide result.
module matriz_linha_alu
  import matriz_pkg::*;
(
  input  logic [MAT_W-1:0]  a,
  input  logic [MAT_W-1:0]  b,
  input  logic [ELEM_W-1:0] escalar,
  input  logic [2:0]        opcode,
  input  logic [2:0]        n,
  input  logic [2:0]        linha,
  output logic [ROW_W-1:0]  resultado_linha
);

  for (genvar gi = 0; gi < DIM; gi++) begin : g_col
    logic [ELEM_W-1:0] elem;

    // One output column: select the operation, blank columns outside N x N.
    always_comb begin
      elem = '0;
      if (gi < int'(n)) begin
        case (opcode)
          OP_ADD: begin
            elem = $signed(a[idx(int'(linha), gi) +: ELEM_W])
                 + $signed(b[idx(int'(linha), gi) +: ELEM_W]);
          end
          OP_SUB: begin
            elem = $signed(a[idx(int'(linha), gi) +: ELEM_W])
                 - $signed(b[idx(int'(linha), gi) +: ELEM_W]);
          end
          OP_MUL: begin
            // Dot product over the active inner dimension only.
            for (int k = 0; k < DIM; k++) begin
              if (k < int'(n)) begin
                elem = elem + $signed(a[idx(int'(linha), k) +: ELEM_W])
                            * $signed(b[idx(k, gi) +: ELEM_W]);
              end
            end
          end
          OP_SCALE: begin
            elem = $signed(escalar) * $signed(a[idx(int'(linha), gi) +: ELEM_W]);
          end
          OP_TRANSPOSE: begin
            elem = a[idx(gi, int'(linha)) +: ELEM_W];
          end
          default: elem = '0;
        endcase
      end
    end

    assign resultado_linha[gi*ELEM_W +: ELEM_W] = elem;
  end

endmodule

// File: rtl/matriz_ctrl.sv
// Sequencing controller: accepts a command on start, computes the result one
// row per clock through the row ALU, pulses done and holds the result until
// the next accepted command. Rejected commands pulse done together with erro.
module matriz_ctrl
  import matriz_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [2:0]        tamanho,
  input  logic [ELEM_W-1:0] escalar,
  input  logic [MAT_W-1:0]  matriz_a,
  input  logic [MAT_W-1:0]  matriz_b,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output logic [MAT_W-1:0]  resultado
);

  estado_t           estado_reg;
  logic [2:0]        linha_reg;
  logic [2:0]        op_reg;
  logic [2:0]        n_reg;
  logic [ELEM_W-1:0] escalar_reg;
  logic [MAT_W-1:0]  a_reg;
  logic [MAT_W-1:0]  b_reg;
  logic [MAT_W-1:0]  resultado_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              erro_reg;
  logic [ROW_W-1:0]  linha_next;

  // The ALU only ever sees latched operands, so host-side changes while busy
  // cannot disturb a command in flight.
  matriz_linha_alu u_alu (
    .a               (a_reg),
    .b               (b_reg),
    .escalar         (escalar_reg),
    .opcode          (op_reg),
    .n               (n_reg),
    .linha           (linha_reg),
    .resultado_linha (linha_next)
  );

  // Command FSM with row counter, operand latches and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_reg    <= IDLE;
      linha_reg     <= '0;
      op_reg        <= '0;
      n_reg         <= '0;
      escalar_reg   <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      resultado_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      erro_reg      <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the entry into FIM/ERRO raises it.
      done_reg <= 1'b0;
      case (estado_reg)
        IDLE: begin
          if (start) begin
            busy_reg <= 1'b1;
            if (cmd_valido(opcode, tamanho)) begin
              op_reg        <= opcode;
              n_reg         <= tamanho;
              escalar_reg   <= escalar;
              a_reg         <= matriz_a;
              b_reg         <= matriz_b;
              // Start from a blank result so rows/columns beyond N read as 0.
              resultado_reg <= '0;
              erro_reg      <= 1'b0;
              linha_reg     <= '0;
              estado_reg    <= CALC;
            end else begin
              // Rejected command: previous result is left untouched.
              done_reg   <= 1'b1;
              erro_reg   <= 1'b1;
              estado_reg <= ERRO;
            end
          end
        end
        CALC: begin
          resultado_reg[idx(int'(linha_reg), 0) +: ROW_W] <= linha_next;
          if (linha_reg == n_reg - 3'd1) begin
            done_reg   <= 1'b1;
            estado_reg <= FIM;
          end else begin
            linha_reg <= linha_reg + 3'd1;
          end
        end
        FIM, ERRO: begin
          busy_reg   <= 1'b0;
          estado_reg <= IDLE;
        end
        default: begin
          busy_reg   <= 1'b0;
          estado_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign erro      = erro_reg;
  assign resultado = resultado_reg;

endmodule
